// File: rtl/serial_adder_nbit.sv
// Multi-cycle ripple adder/subtractor: BPC bits per clock through one adder slice,
// carry registered between chunks, start/done handshake around a three-state FSM.
module serial_adder_nbit #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov,
    output logic             busy,
    output logic             done
);

    localparam int STEPS = WIDTH / BPC;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] op_a, op_b, psum, psum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             accept, last;
    logic [BPC-1:0]   a_k, b_k, sum_k;
    logic             c_out, ov_k;

    // Handshake: start is a request honoured only in IDLE or DONE (busy low);
    // done is high for exactly the one cycle spent in DONE after each operation.
    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (cnt == CW'(STEPS - 1));

    // Operands shift right one chunk per step, so the live chunk is always the low BPC bits.
    assign a_k = op_a[BPC-1:0];
    assign b_k = op_b[BPC-1:0];
    assign {c_out, sum_k} = {1'b0, a_k} + {1'b0, b_k} + {{BPC{1'b0}}, carry};

    // On the final step the live chunk holds the MSBs of a, b' and the result.
    assign ov_k     = (a_k[BPC-1] == b_k[BPC-1]) && (sum_k[BPC-1] != a_k[BPC-1]);
    assign psum_nxt = WIDTH'({sum_k, psum} >> BPC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            co    <= 1'b0;
            ov    <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b ^ {WIDTH{sub}};
            psum  <= '0;
            carry <= sub ? 1'b1 : ci;
            cnt   <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> BPC;
            op_b  <= op_b >> BPC;
            psum  <= psum_nxt;
            carry <= c_out;
            cnt   <= cnt + 1'b1;
            if (last) begin
                s  <= psum_nxt;
                co <= c_out;
                ov <= ov_k;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Directed bench for serial_adder_nbit: three instances (W8/BPC1, W8/BPC2, W4/BPC1)
// sharing one clock and reset, each scenario in its own task.
module tb_serial_adder_nbit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       st0, sb0, ci0, co0, ov0, bz0, dn0;
    logic [7:0] a0, b0, s0;
    logic       st1, sb1, ci1, co1, ov1, bz1, dn1;
    logic [7:0] a1, b1, s1;
    logic       st2, sb2, ci2, co2, ov2, bz2, dn2;
    logic [3:0] a2, b2, s2;

    int checks = 0;
    int errors = 0;

    serial_adder_nbit #(.WIDTH(8), .BPC(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .sub(sb0), .a(a0), .b(b0), .ci(ci0),
        .s(s0), .co(co0), .ov(ov0), .busy(bz0), .done(dn0));
    serial_adder_nbit #(.WIDTH(8), .BPC(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .sub(sb1), .a(a1), .b(b1), .ci(ci1),
        .s(s1), .co(co1), .ov(ov1), .busy(bz1), .done(dn1));
    serial_adder_nbit #(.WIDTH(4), .BPC(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .sub(sb2), .a(a2), .b(b2), .ci(ci2),
        .s(s2), .co(co2), .ov(ov2), .busy(bz2), .done(dn2));

    task automatic drive(input int d, input logic stv, input logic [7:0] av, input logic [7:0] bv,
                         input logic civ, input logic subv);
        case (d)
            0: begin st0 = stv; a0 = av; b0 = bv; ci0 = civ; sb0 = subv; end
            1: begin st1 = stv; a1 = av; b1 = bv; ci1 = civ; sb1 = subv; end
            default: begin st2 = stv; a2 = av[3:0]; b2 = bv[3:0]; ci2 = civ; sb2 = subv; end
        endcase
    endtask

    function automatic logic [1:0] get_bd(input int d);
        case (d)
            0:       get_bd = {bz0, dn0};
            1:       get_bd = {bz1, dn1};
            default: get_bd = {bz2, dn2};
        endcase
    endfunction

    // Packed {co, ov, s}, s zero-extended to 8 bits.
    function automatic logic [9:0] get_res(input int d);
        case (d)
            0:       get_res = {co0, ov0, s0};
            1:       get_res = {co1, ov1, s1};
            default: get_res = {co2, ov2, 4'h0, s2};
        endcase
    endfunction

    // Called #1 after a posedge with the DUT idle; operands are zeroed right after accept.
    task automatic do_op(input int d, input logic [7:0] av, input logic [7:0] bv, input logic civ,
                         input logic subv, output logic [9:0] res, output int lat, output int ndone);
        lat = -1; ndone = 0; res = '0;
        drive(d, 1'b1, av, bv, civ, subv);
        @(posedge clk); #1;
        drive(d, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (get_bd(d)[0]) begin
                lat = i; ndone = 1; res = get_res(d);
                break;
            end
        end
        if (lat >= 0) begin
            repeat (3) begin
                @(posedge clk); #1;
                if (get_bd(d)[0]) ndone++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({get_res(d), get_bd(d)} !== 12'h000) begin
                errors++;
                $display("FAIL reset_hold dut%0d: got %h expected 000", d, {get_res(d), get_bd(d)});
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({get_res(d), get_bd(d)} !== 12'h000) begin
                errors++;
                $display("FAIL reset_release dut%0d: got %h expected 000", d, {get_res(d), get_bd(d)});
            end
        end
    endtask

    task automatic test_directed();
        int         td[6];
        logic [7:0] ta[6], tb[6];
        logic       tci[6], tsub[6];
        logic [9:0] texp[6];
        int         tlat[6];
        logic [9:0] res;
        int         lat, nd;
        td   = '{0, 0, 0, 1, 1, 2};
        ta   = '{8'hFF, 8'h05, 8'h07, 8'h7F, 8'h80, 8'h09};
        tb   = '{8'h01, 8'h07, 8'h05, 8'h01, 8'hFF, 8'h08};
        tci  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tsub = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        texp = '{10'h200, 10'h0FE, 10'h202, 10'h180, 10'h37F, 10'h302};
        tlat = '{8, 8, 8, 4, 4, 4};
        for (int i = 0; i < 6; i++) begin
            do_op(td[i], ta[i], tb[i], tci[i], tsub[i], res, lat, nd);
            checks++;
            if (lat != tlat[i] || nd != 1) begin
                errors++;
                $display("FAIL directed_handshake #%0d: got lat=%0d dones=%0d expected lat=%0d dones=1",
                         i, lat, nd, tlat[i]);
            end
            checks++;
            if (res !== texp[i]) begin
                errors++;
                $display("FAIL directed_result #%0d: got {co,ov,s}=%h expected %h", i, res, texp[i]);
            end
        end
    endtask

    task automatic test_exhaustive_w4();
        logic [9:0] res, exp_r;
        logic [4:0] sum5;
        logic       exp_ov;
        int         lat, nd;
        for (int c = 0; c < 2; c++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    do_op(2, 8'(x), 8'(y), c[0], 1'b0, res, lat, nd);
                    sum5   = 5'(x) + 5'(y) + 5'(c);
                    exp_ov = (x[3] == y[3]) && (sum5[3] != x[3]);
                    exp_r  = {sum5[4], exp_ov, 4'h0, sum5[3:0]};
                    checks++;
                    if (lat != 4 || nd != 1) begin
                        errors++;
                        $display("FAIL exh_handshake a=%0d b=%0d ci=%0d: got lat=%0d dones=%0d expected 4/1",
                                 x, y, c, lat, nd);
                    end
                    checks++;
                    if (res !== exp_r) begin
                        errors++;
                        $display("FAIL exh_result a=%0d b=%0d ci=%0d: got %h expected %h", x, y, c, res, exp_r);
                    end
                end
    endtask

    task automatic test_start_during_run();
        logic [9:0] res;
        int         lat, nd, seen;
        do_op(0, 8'h40, 8'h01, 1'b0, 1'b0, res, lat, nd);
        checks++;
        if (res !== 10'h041) begin
            errors++;
            $display("FAIL sdr_setup: got %h expected 041", res);
        end
        drive(0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        drive(0, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if ({get_res(0), get_bd(0)} !== {10'h041, 2'b10}) begin
            errors++;
            $display("FAIL sdr_midrun: got res=%h busy/done=%b expected res=041 busy/done=10",
                     get_res(0), get_bd(0));
        end
        lat = -1; seen = 0; res = '0;
        for (int i = 4; i <= 20; i++) begin
            @(posedge clk); #1;
            if (get_bd(0)[0]) begin
                seen++;
                if (lat < 0) begin lat = i; res = get_res(0); end
            end
        end
        checks++;
        if (lat != 8 || seen != 1) begin
            errors++;
            $display("FAIL sdr_handshake: got lat=%0d dones=%0d expected 8/1", lat, seen);
        end
        checks++;
        if (res !== 10'h046) begin
            errors++;
            $display("FAIL sdr_result: got %h expected 046", res);
        end
    endtask

    task automatic test_back_to_back();
        int         first, second, seen;
        logic [9:0] r1, r2;
        first = -1; second = -1; seen = 0; r1 = '0; r2 = '0;
        drive(0, 1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                checks++;
                if (get_bd(0) !== 2'b10) begin
                    errors++;
                    $display("FAIL b2b_accept: got busy/done=%b expected 10", get_bd(0));
                end
            end
            if (get_bd(0)[0]) begin
                seen++;
                if (first < 0) begin
                    first = i; r1 = get_res(0);
                    drive(0, 1'b1, 8'h03, 8'h02, 1'b0, 1'b0);
                end else if (second < 0) begin
                    second = i; r2 = get_res(0);
                    drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
                end
            end
        end
        checks++;
        if (first != 9 || second != 18 || seen != 2) begin
            errors++;
            $display("FAIL b2b_timing: got done at %0d,%0d count=%0d expected 9,18 count=2", first, second, seen);
        end
        checks++;
        if ({r1, r2} !== {10'h003, 10'h005}) begin
            errors++;
            $display("FAIL b2b_result: got %h,%h expected 003,005", r1, r2);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [9:0] res;
        int         lat, nd, spurious;
        drive(0, 1'b1, 8'h33, 8'h44, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({get_res(0), get_bd(0)} !== 12'h000) begin
            errors++;
            $display("FAIL rst_midrun: got %h expected 000", {get_res(0), get_bd(0)});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        spurious = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (get_bd(0) != 2'b00) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL rst_no_done: got %0d busy/done cycles expected 0", spurious);
        end
        do_op(0, 8'h10, 8'h20, 1'b0, 1'b0, res, lat, nd);
        checks++;
        if (lat != 8 || nd != 1 || res !== 10'h030) begin
            errors++;
            $display("FAIL rst_recover: got lat=%0d dones=%0d res=%h expected 8/1/030", lat, nd, res);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_exhaustive_w4();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
